// File: rtl/pmp_pkg.sv
// Shared PMP types and constants for the CSR register file and the compare logic.
// Optional feature macro PMP_NA4_EN: when defined, A=NA4 writes are kept, otherwise stored as OFF.
package pmp_pkg;

   typedef struct packed {
      logic       lock;
      logic [1:0] rsvd;
      logic [1:0] a;
      logic       x;
      logic       w;
      logic       r;
   } pmp_cfg_t;

   typedef enum logic [1:0] {
      A_OFF   = 2'd0,
      A_TOR   = 2'd1,
      A_NA4   = 2'd2,
      A_NAPOT = 2'd3
   } pmp_a_e;

   localparam logic [1:0]  PRIV_MACHINE = 2'b11;
   localparam logic [11:0] PMPCFG_BASE  = 12'h3A0;
   localparam logic [11:0] PMPADDR_BASE = 12'h3B0;

   // Legalise one written cfg byte: reserved bits read as zero, RW=01 is not a legal combination.
   function automatic pmp_cfg_t pmp_cfg_warl(input logic [7:0] wbyte);
      pmp_cfg_t c;
      c      = pmp_cfg_t'(wbyte);
      c.rsvd = 2'b00;
      if (c.w && !c.r) begin
         c.w = 1'b0;
      end
`ifndef PMP_NA4_EN
      if (c.a == A_NA4) begin
         c.a = A_OFF;
      end
`endif
      return c;
   endfunction

endpackage

// File: rtl/pmp_napot_mask_gen.sv
// Per-entry compare mask: NAPOT clears the trailing-ones run of pmpaddr plus the next bit.
// Every other A mode compares all bits.
module pmp_napot_mask_gen
   import pmp_pkg::*;
#(
   parameter int ADDR_WIDTH = 32
) (
   input  logic [ADDR_WIDTH-1:0] p,
   input  logic [1:0]            a,
   output logic [ADDR_WIDTH-1:0] mask
);

   always_comb begin
      if (a == A_NAPOT) begin
         mask = ~(p ^ (p + ADDR_WIDTH'(1)));
      end else begin
         mask = '1;
      end
   end

endmodule

// File: rtl/pmp_csr_regfile.sv
// PMP CSR register file: pmpcfg/pmpaddr storage with WARL and lock rules, plus registered NAPOT masks.
// Optional feature macro PMP_NA4_EN (applied in pmp_pkg::pmp_cfg_warl) keeps A=NA4 writes.
module pmp_csr_regfile
   import pmp_pkg::*;
#(
   parameter int PMP_CHANNEL_NUM = 32,
   parameter int ADDR_WIDTH      = 32,
   parameter int CSR_ADDR_WIDTH  = 12
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      csr_req_vld,
   output logic                      csr_req_rdy,
   input  logic                      csr_req_wr,
   input  logic [CSR_ADDR_WIDTH-1:0] csr_req_addr,
   input  logic [31:0]               csr_req_wdata,
   output logic                      csr_rsp_vld,
   output logic                      csr_rsp_hit,
   output logic [31:0]               csr_rsp_rdata,
   output pmp_cfg_t                  v_pmp_cfg [PMP_CHANNEL_NUM],
   output logic [ADDR_WIDTH-1:0]     v_pmp_addr [PMP_CHANNEL_NUM],
   output logic [ADDR_WIDTH-1:0]     v_pmp_napot_mask [PMP_CHANNEL_NUM],
   output logic                      pmp_update
);

   localparam int CFG_REGS = PMP_CHANNEL_NUM / 4;

   typedef enum logic [1:0] {IDLE, COMMIT, MASK} state_e;

   state_e                    state_q, state_d;
   logic                      req_wr_q;
   logic [CSR_ADDR_WIDTH-1:0] req_addr_q;
   logic [31:0]               req_wdata_q;
   logic                      changed_q;

   pmp_cfg_t                  cfg_q   [PMP_CHANNEL_NUM];
   pmp_cfg_t                  cfg_new [PMP_CHANNEL_NUM];
   logic [ADDR_WIDTH-1:0]     addr_q  [PMP_CHANNEL_NUM];
   logic [ADDR_WIDTH-1:0]     mask_q  [PMP_CHANNEL_NUM];
   logic [ADDR_WIDTH-1:0]     mask_d  [PMP_CHANNEL_NUM];

   logic [CSR_ADDR_WIDTH-1:0] cfg_off, addr_off;
   logic                      cfg_hit, addr_hit, req_hit, changed;
   logic [PMP_CHANNEL_NUM-1:0] lock_vec, tor_lock, addr_locked, cfg_we, addr_we;
   logic [31:0]               rd_data;

   always_comb begin
      cfg_off  = req_addr_q - CSR_ADDR_WIDTH'(PMPCFG_BASE);
      addr_off = req_addr_q - CSR_ADDR_WIDTH'(PMPADDR_BASE);
      cfg_hit  = cfg_off < CSR_ADDR_WIDTH'(CFG_REGS);
      addr_hit = addr_off < CSR_ADDR_WIDTH'(PMP_CHANNEL_NUM);
      req_hit  = cfg_hit | addr_hit;
   end

   always_comb begin
      for (int i = 0; i < PMP_CHANNEL_NUM; i++) begin
         lock_vec[i] = cfg_q[i].lock;
         tor_lock[i] = cfg_q[i].lock && (cfg_q[i].a == A_TOR);
      end
   end

   // A locked TOR entry also freezes the pmpaddr below it, since that register is its lower bound.
   assign addr_locked = lock_vec | {1'b0, tor_lock[PMP_CHANNEL_NUM-1:1]};

   always_comb begin
      changed = 1'b0;
      for (int i = 0; i < PMP_CHANNEL_NUM; i++) begin
         cfg_new[i] = pmp_cfg_warl(req_wdata_q[8*(i%4) +: 8]);
         cfg_we[i]  = req_wr_q && cfg_hit && (cfg_off == CSR_ADDR_WIDTH'(i/4)) && !lock_vec[i];
         addr_we[i] = req_wr_q && addr_hit && (addr_off == CSR_ADDR_WIDTH'(i)) && !addr_locked[i];
         if (cfg_we[i] && (cfg_new[i] != cfg_q[i])) begin
            changed = 1'b1;
         end
         if (addr_we[i] && (req_wdata_q[ADDR_WIDTH-1:0] != addr_q[i])) begin
            changed = 1'b1;
         end
      end
   end

   always_comb begin
      rd_data = '0;
      for (int i = 0; i < PMP_CHANNEL_NUM; i++) begin
         if (cfg_hit && (cfg_off == CSR_ADDR_WIDTH'(i/4))) begin
            rd_data[8*(i%4) +: 8] = cfg_q[i];
         end
         if (addr_hit && (addr_off == CSR_ADDR_WIDTH'(i))) begin
            rd_data = 32'(addr_q[i]);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         req_wr_q    <= 1'b0;
         req_addr_q  <= '0;
         req_wdata_q <= '0;
      end else if (state_q == IDLE && csr_req_vld) begin
         req_wr_q    <= csr_req_wr;
         req_addr_q  <= csr_req_addr;
         req_wdata_q <= csr_req_wdata;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         changed_q <= 1'b0;
         for (int i = 0; i < PMP_CHANNEL_NUM; i++) begin
            cfg_q[i]  <= '0;
            addr_q[i] <= '0;
         end
      end else if (state_q == COMMIT) begin
         changed_q <= changed;
         for (int i = 0; i < PMP_CHANNEL_NUM; i++) begin
            if (cfg_we[i]) begin
               cfg_q[i] <= cfg_new[i];
            end
            if (addr_we[i]) begin
               addr_q[i] <= req_wdata_q[ADDR_WIDTH-1:0];
            end
         end
      end
   end

   // Masks are only refreshed in MASK; every cfg/addr change passes through it, so untouched entries reload the same value.
   for (genvar g = 0; g < PMP_CHANNEL_NUM; g++) begin : g_mask
      pmp_napot_mask_gen #(.ADDR_WIDTH(ADDR_WIDTH)) u_mask_gen (
         .p    (addr_q[g]),
         .a    (cfg_q[g].a),
         .mask (mask_d[g])
      );
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < PMP_CHANNEL_NUM; i++) begin
            mask_q[i] <= '1;
         end
      end else if (state_q == MASK) begin
         for (int i = 0; i < PMP_CHANNEL_NUM; i++) begin
            mask_q[i] <= mask_d[i];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (csr_req_vld) state_d = COMMIT;
         COMMIT:  state_d = (req_wr_q && req_hit) ? MASK : IDLE;
         MASK:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      csr_req_rdy   = 1'b0;
      csr_rsp_vld   = 1'b0;
      csr_rsp_hit   = 1'b0;
      csr_rsp_rdata = '0;
      pmp_update    = 1'b0;
      case (state_q)
         IDLE: csr_req_rdy = 1'b1;
         COMMIT: begin
            if (!(req_wr_q && req_hit)) begin
               csr_rsp_vld   = 1'b1;
               csr_rsp_hit   = req_hit;
               csr_rsp_rdata = req_wr_q ? 32'h0 : rd_data;
            end
         end
         MASK: begin
            csr_rsp_vld = 1'b1;
            csr_rsp_hit = 1'b1;
            pmp_update  = changed_q;
         end
         default: ;
      endcase
   end

   assign v_pmp_cfg        = cfg_q;
   assign v_pmp_addr       = addr_q;
   assign v_pmp_napot_mask = mask_q;

endmodule

// File: tb/tb_pmp_csr_regfile.sv
// Directed self-checking bench for pmp_csr_regfile (default 32 entries, 32-bit pmpaddr).
// Expected NA4 behaviour follows the PMP_NA4_EN macro of the build.
module tb_pmp_csr_regfile;
   import pmp_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        csr_req_vld, csr_req_rdy, csr_req_wr;
   logic [11:0] csr_req_addr;
   logic [31:0] csr_req_wdata;
   logic        csr_rsp_vld, csr_rsp_hit;
   logic [31:0] csr_rsp_rdata;
   pmp_cfg_t    v_pmp_cfg [32];
   logic [31:0] v_pmp_addr [32];
   logic [31:0] v_pmp_napot_mask [32];
   logic        pmp_update;

   int          n_cmp = 0;
   int          n_err = 0;
   int          rsp_lat;
   int          upd_cnt;
   logic        rsp_hit_s;
   logic [31:0] rsp_data_s;
   logic [7:0]  cfg_at_rsp [32];
   logic [31:0] addr_at_rsp [32];
   logic [31:0] mask_at_rsp [32];

   pmp_csr_regfile dut (
      .clk              (clk),
      .rst              (rst),
      .csr_req_vld      (csr_req_vld),
      .csr_req_rdy      (csr_req_rdy),
      .csr_req_wr       (csr_req_wr),
      .csr_req_addr     (csr_req_addr),
      .csr_req_wdata    (csr_req_wdata),
      .csr_rsp_vld      (csr_rsp_vld),
      .csr_rsp_hit      (csr_rsp_hit),
      .csr_rsp_rdata    (csr_rsp_rdata),
      .v_pmp_cfg        (v_pmp_cfg),
      .v_pmp_addr       (v_pmp_addr),
      .v_pmp_napot_mask (v_pmp_napot_mask),
      .pmp_update       (pmp_update)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog");
   end

   // Issues one request from IDLE, records latency/response/update pulses, then settles one cycle.
   task automatic do_req(input logic wr, input logic [11:0] addr, input logic [31:0] wdata);
      csr_req_vld   = 1'b1;
      csr_req_wr    = wr;
      csr_req_addr  = addr;
      csr_req_wdata = wdata;
      rsp_lat = -1; rsp_hit_s = 1'b0; rsp_data_s = '0; upd_cnt = 0;
      for (int c = 1; c <= 10; c++) begin
         @(posedge clk); #1;
         csr_req_vld = 1'b0;
         if (pmp_update) upd_cnt++;
         if (csr_rsp_vld) begin
            rsp_lat    = c;
            rsp_hit_s  = csr_rsp_hit;
            rsp_data_s = csr_rsp_rdata;
            for (int i = 0; i < 32; i++) begin
               cfg_at_rsp[i]  = v_pmp_cfg[i];
               addr_at_rsp[i] = v_pmp_addr[i];
               mask_at_rsp[i] = v_pmp_napot_mask[i];
            end
            break;
         end
      end
      n_cmp++;
      if (rsp_lat < 0) begin
         n_err++;
         $display("[TB] FAIL rsp_timeout addr=%h: got no response, expected one within 10 cycles", addr);
      end
      @(posedge clk); #1;
      if (pmp_update) upd_cnt++;
   endtask

   task automatic test_reset();
      int bad;
      rst = 1'b1; csr_req_vld = 1'b0; csr_req_wr = 1'b0; csr_req_addr = '0; csr_req_wdata = '0;
      repeat (2) @(posedge clk);
      #1;
      n_cmp++; if (csr_req_rdy !== 1'b1) begin n_err++; $display("[TB] FAIL reset_rdy: got %b expected 1", csr_req_rdy); end
      n_cmp++; if ({csr_rsp_vld, csr_rsp_hit, pmp_update} !== 3'b000) begin n_err++; $display("[TB] FAIL reset_rsp: got vld/hit/upd=%b expected 000", {csr_rsp_vld, csr_rsp_hit, pmp_update}); end
      n_cmp++; if (csr_rsp_rdata !== 32'h0) begin n_err++; $display("[TB] FAIL reset_rdata: got %h expected 0", csr_rsp_rdata); end
      bad = 0;
      for (int i = 0; i < 32; i++) begin
         if (v_pmp_napot_mask[i] !== 32'hFFFF_FFFF || v_pmp_addr[i] !== 32'h0 || v_pmp_cfg[i] !== 8'h00) bad++;
      end
      n_cmp++; if (bad !== 0) begin n_err++; $display("[TB] FAIL reset_vectors: got %0d bad entries expected 0", bad); end
      @(negedge clk); rst = 1'b0;
      @(posedge clk); #1;
      do_req(1'b0, 12'h3A0, 32'h0);
      n_cmp++; if (rsp_lat !== 1 || rsp_hit_s !== 1'b1 || rsp_data_s !== 32'h0) begin n_err++; $display("[TB] FAIL read_3a0: got lat=%0d hit=%b data=%h expected lat=1 hit=1 data=0", rsp_lat, rsp_hit_s, rsp_data_s); end
      do_req(1'b0, 12'h3B5, 32'h0);
      n_cmp++; if (rsp_lat !== 1 || rsp_hit_s !== 1'b1 || rsp_data_s !== 32'h0) begin n_err++; $display("[TB] FAIL read_3b5: got lat=%0d hit=%b data=%h expected lat=1 hit=1 data=0", rsp_lat, rsp_hit_s, rsp_data_s); end
   endtask

   task automatic test_napot();
      do_req(1'b1, 12'h3B2, 32'h0000_0FFF);
      n_cmp++; if (rsp_lat !== 2 || rsp_hit_s !== 1'b1 || rsp_data_s !== 32'h0) begin n_err++; $display("[TB] FAIL wr_3b2_rsp: got lat=%0d hit=%b data=%h expected lat=2 hit=1 data=0", rsp_lat, rsp_hit_s, rsp_data_s); end
      n_cmp++; if (addr_at_rsp[2] !== 32'h0000_0FFF) begin n_err++; $display("[TB] FAIL addr2_at_n2: got %h expected 00000fff", addr_at_rsp[2]); end
      n_cmp++; if (upd_cnt !== 1) begin n_err++; $display("[TB] FAIL upd_wr_3b2: got %0d pulses expected 1", upd_cnt); end
      do_req(1'b1, 12'h3B3, 32'hFFFF_FFFF);
      do_req(1'b1, 12'h3A0, 32'h1818_1800);
      n_cmp++; if (rsp_lat !== 2 || upd_cnt !== 1) begin n_err++; $display("[TB] FAIL wr_cfg_napot: got lat=%0d upd=%0d expected lat=2 upd=1", rsp_lat, upd_cnt); end
      n_cmp++; if (cfg_at_rsp[2] !== 8'h18 || mask_at_rsp[2] !== 32'hFFFF_FFFF) begin n_err++; $display("[TB] FAIL napot_n2: got cfg=%h mask=%h expected cfg=18 mask=ffffffff", cfg_at_rsp[2], mask_at_rsp[2]); end
      n_cmp++; if (v_pmp_napot_mask[2] !== 32'hFFFF_E000) begin n_err++; $display("[TB] FAIL mask2_n3: got %h expected ffffe000", v_pmp_napot_mask[2]); end
      n_cmp++; if (v_pmp_napot_mask[3] !== 32'h0) begin n_err++; $display("[TB] FAIL mask3_allones_addr: got %h expected 00000000", v_pmp_napot_mask[3]); end
      n_cmp++; if (v_pmp_napot_mask[1] !== 32'hFFFF_FFFE) begin n_err++; $display("[TB] FAIL mask1_zero_addr: got %h expected fffffffe", v_pmp_napot_mask[1]); end
      do_req(1'b0, 12'h3A0, 32'h0);
      n_cmp++; if (rsp_data_s !== 32'h1818_1800) begin n_err++; $display("[TB] FAIL read_cfg_napot: got %h expected 18181800", rsp_data_s); end
   endtask

   task automatic test_warl();
      do_req(1'b1, 12'h3A0, 32'h0000_0002);
      do_req(1'b0, 12'h3A0, 32'h0);
      n_cmp++; if (rsp_data_s !== 32'h0) begin n_err++; $display("[TB] FAIL warl_w_only: got %h expected 00000000", rsp_data_s); end
      n_cmp++; if (v_pmp_napot_mask[2] !== 32'hFFFF_FFFF) begin n_err++; $display("[TB] FAIL mask2_off: got %h expected ffffffff", v_pmp_napot_mask[2]); end
      do_req(1'b1, 12'h3A0, 32'h7F63_6600);
      do_req(1'b0, 12'h3A0, 32'h0);
      n_cmp++; if (rsp_data_s !== 32'h1F03_0400) begin n_err++; $display("[TB] FAIL warl_rsvd: got %h expected 1f030400", rsp_data_s); end
   endtask

   task automatic test_na4();
      logic [31:0] exp_na4;
`ifdef PMP_NA4_EN
      exp_na4 = 32'h0000_0010;
`else
      exp_na4 = 32'h0000_0000;
`endif
      do_req(1'b1, 12'h3A0, 32'h0000_0010);
      do_req(1'b0, 12'h3A0, 32'h0);
      n_cmp++; if (rsp_data_s !== exp_na4) begin n_err++; $display("[TB] FAIL na4_readback: got %h expected %h", rsp_data_s, exp_na4); end
      n_cmp++; if (v_pmp_napot_mask[0] !== 32'hFFFF_FFFF) begin n_err++; $display("[TB] FAIL na4_mask: got %h expected ffffffff", v_pmp_napot_mask[0]); end
   endtask

   task automatic test_lock();
      do_req(1'b1, 12'h3B0, 32'h0000_0100);
      do_req(1'b1, 12'h3B1, 32'h0000_0200);
      do_req(1'b1, 12'h3A0, 32'h0000_8800);
      do_req(1'b0, 12'h3A0, 32'h0);
      n_cmp++; if (rsp_data_s !== 32'h0000_8800) begin n_err++; $display("[TB] FAIL lock_cfg_set: got %h expected 00008800", rsp_data_s); end
      do_req(1'b1, 12'h3B0, 32'h0000_1234);
      n_cmp++; if (rsp_lat !== 2 || upd_cnt !== 0) begin n_err++; $display("[TB] FAIL tor_lock_wr: got lat=%0d upd=%0d expected lat=2 upd=0", rsp_lat, upd_cnt); end
      do_req(1'b1, 12'h3B1, 32'h0000_1234);
      n_cmp++; if (rsp_lat !== 2 || upd_cnt !== 0) begin n_err++; $display("[TB] FAIL lock_wr: got lat=%0d upd=%0d expected lat=2 upd=0", rsp_lat, upd_cnt); end
      do_req(1'b0, 12'h3B0, 32'h0);
      n_cmp++; if (rsp_data_s !== 32'h0000_0100) begin n_err++; $display("[TB] FAIL tor_lock_addr0: got %h expected 00000100", rsp_data_s); end
      do_req(1'b0, 12'h3B1, 32'h0);
      n_cmp++; if (rsp_data_s !== 32'h0000_0200) begin n_err++; $display("[TB] FAIL lock_addr1: got %h expected 00000200", rsp_data_s); end
      do_req(1'b1, 12'h3B2, 32'h0000_1234);
      n_cmp++; if (upd_cnt !== 1 || v_pmp_addr[2] !== 32'h0000_1234) begin n_err++; $display("[TB] FAIL unlocked_addr2: got upd=%0d addr=%h expected upd=1 addr=00001234", upd_cnt, v_pmp_addr[2]); end
      do_req(1'b1, 12'h3A0, 32'h0000_0001);
      do_req(1'b0, 12'h3A0, 32'h0);
      n_cmp++; if (rsp_data_s !== 32'h0000_8801) begin n_err++; $display("[TB] FAIL lock_partial_cfg: got %h expected 00008801", rsp_data_s); end
   endtask

   task automatic test_miss_boundary();
      do_req(1'b1, 12'h3A9, 32'hFFFF_FFFF);
      n_cmp++; if (rsp_lat !== 1 || rsp_hit_s !== 1'b0 || rsp_data_s !== 32'h0 || upd_cnt !== 0) begin n_err++; $display("[TB] FAIL wr_miss: got lat=%0d hit=%b data=%h upd=%0d expected 1/0/0/0", rsp_lat, rsp_hit_s, rsp_data_s, upd_cnt); end
      do_req(1'b0, 12'h3A0, 32'h0);
      n_cmp++; if (rsp_data_s !== 32'h0000_8801) begin n_err++; $display("[TB] FAIL miss_no_effect: got %h expected 00008801", rsp_data_s); end
      do_req(1'b0, 12'h3A8, 32'h0);
      n_cmp++; if (rsp_hit_s !== 1'b0) begin n_err++; $display("[TB] FAIL cfg_range_end: got hit=%b expected 0", rsp_hit_s); end
      do_req(1'b0, 12'h3CF, 32'h0);
      n_cmp++; if (rsp_hit_s !== 1'b1 || rsp_data_s !== 32'h0) begin n_err++; $display("[TB] FAIL addr_last: got hit=%b data=%h expected hit=1 data=0", rsp_hit_s, rsp_data_s); end
      do_req(1'b0, 12'h3D0, 32'h0);
      n_cmp++; if (rsp_hit_s !== 1'b0) begin n_err++; $display("[TB] FAIL addr_range_end: got hit=%b expected 0", rsp_hit_s); end
   endtask

   task automatic test_back_to_back();
      int nrsp, lat2, rdy_busy;
      logic [31:0] data2;
      nrsp = 0; lat2 = -1; rdy_busy = 0; data2 = '0;
      csr_req_vld = 1'b1; csr_req_wr = 1'b1; csr_req_addr = 12'h3B3; csr_req_wdata = 32'h7;
      for (int c = 1; c <= 8; c++) begin
         @(posedge clk); #1;
         if (c == 1) begin
            csr_req_wr = 1'b0; csr_req_wdata = 32'h0;
         end
         if ((c == 1 || c == 2) && csr_req_rdy) rdy_busy++;
         if (csr_rsp_vld) begin
            nrsp++;
            if (nrsp == 2) begin lat2 = c; data2 = csr_rsp_rdata; end
         end
         if (c == 4) csr_req_vld = 1'b0;
      end
      n_cmp++; if (rdy_busy !== 0) begin n_err++; $display("[TB] FAIL busy_rdy: got rdy high %0d busy cycles expected 0", rdy_busy); end
      n_cmp++; if (nrsp !== 2 || lat2 !== 4) begin n_err++; $display("[TB] FAIL busy_accept: got %0d responses, second at %0d expected 2 at 4", nrsp, lat2); end
      n_cmp++; if (data2 !== 32'h7) begin n_err++; $display("[TB] FAIL busy_read_data: got %h expected 00000007", data2); end
   endtask

   task automatic test_reset_mid();
      int late;
      csr_req_vld = 1'b1; csr_req_wr = 1'b1; csr_req_addr = 12'h3B4; csr_req_wdata = 32'h55;
      @(posedge clk); #1;
      csr_req_vld = 1'b0;
      @(posedge clk); #1;
      n_cmp++; if (csr_rsp_vld !== 1'b1 || pmp_update !== 1'b1) begin n_err++; $display("[TB] FAIL mask_state: got vld=%b upd=%b expected 1/1", csr_rsp_vld, pmp_update); end
      rst = 1'b1; #1;
      n_cmp++; if (csr_rsp_vld !== 1'b0 || csr_req_rdy !== 1'b1 || pmp_update !== 1'b0) begin n_err++; $display("[TB] FAIL rst_mid: got vld=%b rdy=%b upd=%b expected 0/1/0", csr_rsp_vld, csr_req_rdy, pmp_update); end
      n_cmp++; if (v_pmp_cfg[1] !== 8'h00 || v_pmp_addr[4] !== 32'h0) begin n_err++; $display("[TB] FAIL rst_mid_state: got cfg1=%h addr4=%h expected 00/0", v_pmp_cfg[1], v_pmp_addr[4]); end
      @(negedge clk); rst = 1'b0;
      late = 0;
      repeat (3) begin
         @(posedge clk); #1;
         if (csr_rsp_vld) late++;
      end
      n_cmp++; if (late !== 0) begin n_err++; $display("[TB] FAIL rst_dropped: got %0d late responses expected 0", late); end
      do_req(1'b1, 12'h3B1, 32'h42);
      do_req(1'b0, 12'h3B1, 32'h0);
      n_cmp++; if (rsp_data_s !== 32'h42) begin n_err++; $display("[TB] FAIL lock_cleared: got %h expected 00000042", rsp_data_s); end
   endtask

   initial begin
      test_reset();
      test_napot();
      test_warl();
      test_na4();
      test_lock();
      test_miss_boundary();
      test_back_to_back();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
